// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encodings and
// the default datapath width.
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bi, with the borrow out on bo.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB-first, one bit per clock,
// and presents a registered result with a one-cycle done pulse.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             d_bit, bo_bit;

    full_subtractor u_fs (
        .x  (a_q[0]),
        .y  (b_q[0]),
        .bi (br_q),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        br_d    = br_q;
        part_d  = part_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    cnt_d   = '0;
                    part_d  = '0;
                end
            end
            SHIFT: begin
                // Result bits enter at the MSB so the LSB lands in bit 0 after WIDTH steps.
                part_d = {d_bit, part_q[WIDTH-1:1]};
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                br_d   = bo_bit;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = part_d;
                    bout_d  = bo_bit;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            part_q  <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            br_q    <= br_d;
            part_q  <= part_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT) || (state_q == DONE);
    assign done = (state_q == DONE);
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with hand-computed results.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       bin;
    logic       busy, done;
    logic [7:0] diff;
    logic       bout;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, then watch a bounded window of edges for done.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                         output int done_at, output int pulses);
        a = av; b = bv; bin = bi; start = 1'b1;
        tick();
        start = 1'b0;
        done_at = -1; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done) begin
                if (done_at < 0) done_at = k;
                pulses++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL reset_diff got %h exp 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL reset_bout got %b exp 0", bout); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_latency();
        int busy_seen = 0;
        int done_at = -1, pulses = 0;
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k <= 8 && busy) busy_seen++;
            if (done) begin
                if (done_at < 0) done_at = k;
                pulses++;
            end
        end
        checks++; if (busy_seen != 8) begin errors++; $display("FAIL basic_busy got %0d exp 8", busy_seen); end
        checks++; if (done_at != 8) begin errors++; $display("FAIL basic_latency got %0d exp 8", done_at); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL basic_pulses got %0d exp 1", pulses); end
        checks++; if (diff !== 8'd63) begin errors++; $display("FAIL basic_diff got %0d exp 63", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL basic_bout got %b exp 0", bout); end
        // Result must survive input churn while idle.
        a = 8'hFF; b = 8'h00; bin = 1'b1;
        tick(); tick();
        checks++; if (diff !== 8'd63) begin errors++; $display("FAIL hold_diff got %0d exp 63", diff); end
    endtask

    task automatic test_vectors();
        logic [7:0] va [5] = '{8'h00, 8'h55, 8'h80, 8'h00, 8'hFF};
        logic [7:0] vb [5] = '{8'h01, 8'h55, 8'h7F, 8'hFF, 8'h00};
        logic       vi [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] ed [5] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'hFE};
        logic       eb [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        int done_at, pulses;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vi[i], done_at, pulses);
            checks++; if (done_at != 8 || pulses != 1) begin errors++; $display("FAIL vec%0d_timing got at=%0d n=%0d exp at=8 n=1", i, done_at, pulses); end
            checks++; if (diff !== ed[i]) begin errors++; $display("FAIL vec%0d_diff got %h exp %h", i, diff, ed[i]); end
            checks++; if (bout !== eb[i]) begin errors++; $display("FAIL vec%0d_bout got %b exp %b", i, bout, eb[i]); end
        end
    endtask

    task automatic test_start_during_shift();
        int done_at = -1, pulses = 0;
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            if (k == 2) begin start = 1'b1; a = 8'hFF; b = 8'h00; bin = 1'b1; end
            if (k == 6) start = 1'b0;
            tick();
            if (done) begin
                if (done_at < 0) done_at = k;
                pulses++;
            end
        end
        checks++; if (done_at != 8) begin errors++; $display("FAIL ignore_latency got %0d exp 8", done_at); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
        checks++; if (diff !== 8'd63) begin errors++; $display("FAIL ignore_diff got %0d exp 63", diff); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        int bad_gap = 0;
        int last = -1;
        int bad_res = 0;
        a = 8'h80; b = 8'h7F; bin = 1'b0; start = 1'b1;
        tick();
        for (int k = 1; k <= 42; k++) begin
            if (k == 30) start = 1'b0;
            tick();
            if (done) begin
                pulses++;
                if ((last < 0 && k != 8) || (last >= 0 && k - last != 10)) bad_gap++;
                if (diff !== 8'h01 || bout !== 1'b0) bad_res++;
                last = k;
            end
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps exp 0", bad_gap); end
        checks++; if (bad_res != 0) begin errors++; $display("FAIL b2b_result got %0d bad results exp 0", bad_res); end
    endtask

    task automatic test_reset_mid_shift();
        int pulses = 0;
        a = 8'd100; b = 8'd37; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done); end
        checks++; if (diff !== 8'h00) begin errors++; $display("FAIL abort_diff got %h exp 00", diff); end
        checks++; if (bout !== 1'b0) begin errors++; $display("FAIL abort_bout got %b exp 0", bout); end
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", pulses); end
        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_prio_busy got %b exp 0", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_prio_idle got %b exp 0", busy); end
    endtask

    initial begin
        test_reset();
        test_basic_latency();
        test_vectors();
        test_start_during_shift();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
